// File: rtl/display_scan_mux_if.sv
// -----------------------------------------------------------------------------
// display_scan_mux_if
// Bundles the digit-load and display-drive signals of display_scan_mux.
//   digits_in    [15:0] four BCD digits, [3:0] = digit 0 (rightmost)
//   digits_valid        one-cycle load strobe for digits_in
//   blank               level, forces all anodes off
//   num          [3:0]  BCD value of the selected digit, to the decoder
//   anodes_n     [3:0]  active-low anode enables, bit i = digit i
//   digit_idx    [1:0]  index of the selected digit
//   frame_done          one-cycle pulse after digit 3's slot ends
// master: upstream time counter / board side; slave: the scan mux.
// -----------------------------------------------------------------------------
interface display_scan_mux_if;
    logic [15:0] digits_in;
    logic        digits_valid;
    logic        blank;
    logic [3:0]  num;
    logic [3:0]  anodes_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    modport master (
        output digits_in, digits_valid, blank,
        input  num, anodes_n, digit_idx, frame_done
    );

    modport slave (
        input  digits_in, digits_valid, blank,
        output num, anodes_n, digit_idx, frame_done
    );
endinterface

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
// Time-multiplexes four BCD digits (HH:MM) onto one seven-segment decoder
// input and drives the active-low common anodes of a 4-digit display.
// Digit data is double-buffered (pending -> shadow) and swapped only at the
// frame boundary, so the upstream counter may load at any cycle.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    display_scan_mux_if.slave (digits_in, digits_valid, blank in;
//          num, anodes_n, digit_idx, frame_done out)
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   DEAD_CYCLES  all-anodes-off cycles at the start of each slot (< REFRESH_DIV)
//
// Optional feature (macro DISPLAY_SCAN_MUX_ZERO_BLANK_EN): leading-zero
// suppression of digit 3, evaluated on the shadow copy.
// -----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    display_scan_mux_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pending_q, pending_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    num_q, num_d;
    logic [3:0]    anodes_q, anodes_d;
    logic          fdone_q, fdone_d;

    logic          slot_end;
    logic          wrap;
    logic [3:0]    nib;
    logic          dead;
    logic          zero_sup;

`ifdef DISPLAY_SCAN_MUX_ZERO_BLANK_EN
    // Hour-tens zero stays dark; shadow only changes at frame edges, so the
    // decision is stable for the whole slot.
    assign zero_sup = (idx_q == 2'd3) && (shadow_q[15:12] == 4'd0);
`else
    assign zero_sup = 1'b0;
`endif

    always_comb begin
        slot_end  = (presc_q == PW'(REFRESH_DIV - 1));
        wrap      = slot_end && (idx_q == 2'd3);

        presc_d   = slot_end ? '0 : presc_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

        // Last strobe in a frame wins.
        pending_d = bus.digits_valid ? bus.digits_in : pending_q;
        // A strobe landing in the wrap cycle bypasses pending so it is not
        // delayed by a whole frame.
        shadow_d  = shadow_q;
        if (wrap)
            shadow_d = bus.digits_valid ? bus.digits_in : pending_q;

        nib       = shadow_q[{idx_q, 2'b00} +: 4];
        dead      = (DEAD_CYCLES > 0) && (presc_q < PW'(DEAD_CYCLES));

        num_d     = nib;
        // Codes above 9 are undefined for the decoder; keep that digit dark.
        if (dead || bus.blank || (nib > 4'd9) || zero_sup)
            anodes_d = 4'hF;
        else
            anodes_d = ~(4'b0001 << idx_q);

        fdone_d   = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            idx_q     <= 2'd0;
            pending_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            num_q     <= 4'h0;
            anodes_q  <= 4'hF;
            fdone_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            num_q     <= num_d;
            anodes_q  <= anodes_d;
            fdone_q   <= fdone_d;
        end
    end

    assign bus.num        = num_q;
    assign bus.anodes_n   = anodes_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = fdone_q;
endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Time-multiplexes four BCD digits (HH:MM) onto a single seven-segment decoder input.
- Drives the active-low common anodes of a 4-digit display.
- Sits directly upstream of the segment decoder: `num` feeds the decoder's 4-bit digit input; `anodes_n` goes to the board pins.
- Digit data is double-buffered and only swapped at frame boundaries, so the time counter can update at any cycle without tearing.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ 2).
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- digits_in  input  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3 (leftmost)
- digits_valid  input  1  one-cycle load strobe for digits_in
- blank  input  1  level; forces all anodes off while high
- num  output  4  BCD value of the currently selected digit, to the decoder
- anodes_n  output  4  active-low anode enables; bit i = digit i
- digit_idx  output  2  index of the currently selected digit
- frame_done  output  1  one-cycle pulse when digit 3's slot ends

Behaviour:
- Reset state (all registered):
  - prescaler = 0, digit_idx = 0, pending = 0, shadow = 0
  - num = 0, anodes_n = 4'b1111, frame_done = 0
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - slot_end is asserted when prescaler == REFRESH_DIV-1.
- Digit index:
  - On slot_end, digit_idx increments modulo 4 (3 → 0).
  - Sequence is 0, 1, 2, 3, 0, ...
- frame_done: registered; high for exactly the one cycle after the edge at which digit_idx goes 3 → 0.
- Load path:
  - digits_valid high → pending <= digits_in at that edge.
  - Several strobes within one frame: last one wins.
- Shadow swap:
  - At the edge where digit_idx wraps 3 → 0, shadow <= pending.
  - If digits_valid is high in that same cycle, shadow <= digits_in directly (the new value shows in the new frame).
- Outputs (registered; one-cycle latency from prescaler/digit_idx state):
  - num = shadow nibble selected by digit_idx.
  - anodes_n = all ones when any of these hold:
    - prescaler < DEAD_CYCLES,
    - blank is high,
    - the selected nibble is > 9 (never drive the decoder's undefined codes onto a lit digit).
  - Otherwise anodes_n = ~(4'b0001 << digit_idx).
  - Exactly one anode (or none) is low at any time.
  - num still updates during dead/blank cycles.
- Reset mid-frame: everything returns to reset values on the next edge; scanning restarts at digit 0 with a dead period.
  - pending contents are lost; the upstream block must re-strobe.
- blank:
  - Affects only anodes_n.
  - Prescaler, index, load and swap continue unaffected.

Optional Feature:
- Macro: DISPLAY_SCAN_MUX_ZERO_BLANK_EN.
- Defined: leading-zero suppression on digit 3 (hour tens).
  - When shadow[15:12] == 0, digit 3's anode stays off for its whole slot.
  - Digits 0–2 are never suppressed.
  - Evaluated on the shadow copy, so it changes only at frame boundaries.
- Undefined: digit 3 shows '0' like any other digit. No extra logic is synthesized.

Test Plan:
- Reset sequencing (REFRESH_DIV=4, DEAD_CYCLES=1): hold reset 3 cycles, then release.
  - anodes_n = 1111 during reset and on the first cycle after.
  - Then anodes_n is 1110 for 3 cycles, 1111 for 1, 1101 for 3, ... 0111; digit_idx follows 0, 1, 2, 3.
  - frame_done pulses once every 16 cycles.
- Tear-free load: load digits_in = 16'h1234 and wait for the next frame boundary, then strobe 16'h5678 while digit_idx = 1.
  - Rest of the frame still shows 4, 3, 2, 1.
  - The next frame shows num = 8, 7, 6, 5 on digits 0–3.
- Simultaneous strobe and swap: pending = 16'h1111; strobe 16'h2222 in the wrap cycle.
  - The new frame shows 2 on all digits; 1 never appears after the wrap.
- Invalid BCD and blank: digits 16'h0A09 → digit 2 anode stays off and its num = 4'hA; the other digits light normally.
  - Assert blank for 10 cycles → anodes_n = 1111 throughout, and digit_idx keeps advancing.
- Mid-frame reset: pulse reset with digit_idx = 2 and prescaler = 2.
  - Next cycle: digit_idx = 0, num = 0, anodes_n = 1111, shadow = 0.
- Zero blank (macro defined): digits 16'h0945.
  - Digit 3 anode is never low; digits 0–2 display 5, 4, 9.
  - Same stimulus with the macro undefined: digit 3 lights with num = 0.
